// File: rtl/ram_pkg.sv
// Shared types and default sizes for the dual-port RAM controller.
package ram_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 8;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

endpackage

// File: rtl/ram_dp_array.sv
// Storage array: one write port and two synchronous read ports. Reads return
// the pre-write word when a write hits the same address on the same edge.
module ram_dp_array
    import ram_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re_a,
    input  logic [ADDR_W-1:0] i_raddr_a,
    output logic [DATA_W-1:0] o_q_a,
    input  logic              i_re_b,
    input  logic [ADDR_W-1:0] i_raddr_b,
    output logic [DATA_W-1:0] o_q_b
);

    logic [DATA_W-1:0] r_mem [2**ADDR_W];
    logic [DATA_W-1:0] r_q_a;
    logic [DATA_W-1:0] r_q_b;

    // Contents are deliberately not reset; only the read registers are.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q_a <= '0;
            r_q_b <= '0;
        end else begin
            if (i_re_a) begin
                r_q_a <= r_mem[i_raddr_a];
            end
            if (i_re_b) begin
                r_q_b <= r_mem[i_raddr_b];
            end
        end
    end

    assign o_q_a = r_q_a;
    assign o_q_b = r_q_b;

endmodule

// File: rtl/ram_dp_ctl.sv
// Dual-port RAM controller: power-up clear FSM, port A data / port B fetch.
// Define RAM_DP_BYPASS_EN to forward a same-address port A write to port B.
module ram_dp_ctl
    import ram_pkg::*;
#(
    parameter int                DATA_W  = DEF_DATA_W,
    parameter int                ADDR_W  = DEF_ADDR_W,
    parameter logic [DATA_W-1:0] CLR_VAL = '0
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              a_en,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_din,
    output logic [DATA_W-1:0] a_dout,
    input  logic              b_en,
    input  logic [ADDR_W-1:0] b_addr,
    output logic [DATA_W-1:0] b_dout,
    output logic              busy,
    output logic              err,
    output state_t            o_dbg_state
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    state_t            r_state;
    logic [ADDR_W-1:0] r_cnt;
    logic              r_busy;
    logic              r_err;

    logic              w_ready;
    logic              w_we;
    logic [ADDR_W-1:0] w_waddr;
    logic [DATA_W-1:0] w_wdata;
    logic              w_re_a;
    logic              w_re_b;
    logic [DATA_W-1:0] w_q_b;

    // a_en/b_en are single-cycle requests with no backpressure: accepted on
    // any edge in READY, dropped during CLEAR where they only raise err.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= CLEAR;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                CLEAR: begin
                    if (a_en || b_en) begin
                        r_err <= 1'b1;
                    end
                    if (r_cnt == LAST_ADDR) begin
                        r_state <= READY;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                READY: begin
                    r_state <= READY;
                end
                default: begin
                    r_state <= CLEAR;
                end
            endcase
        end
    end

    assign w_ready = (r_state == READY);
    assign w_we    = !w_ready || (a_en && a_we);
    assign w_waddr = w_ready ? a_addr : r_cnt;
    assign w_wdata = w_ready ? a_din : CLR_VAL;
    assign w_re_a  = w_ready && a_en;
    assign w_re_b  = w_ready && b_en;

    ram_dp_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk       (clock),
        .rst_n     (reset_n),
        .i_we      (w_we),
        .i_waddr   (w_waddr),
        .i_wdata   (w_wdata),
        .i_re_a    (w_re_a),
        .i_raddr_a (a_addr),
        .o_q_a     (a_dout),
        .i_re_b    (w_re_b),
        .i_raddr_b (b_addr),
        .o_q_b     (w_q_b)
    );

`ifdef RAM_DP_BYPASS_EN
    logic              w_collide;
    logic              r_b_byp;
    logic [DATA_W-1:0] r_b_byp_data;

    assign w_collide = a_en && a_we && (a_addr == b_addr);

    // Selector and data only move on an accepted B read, so b_dout holds otherwise.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_b_byp      <= 1'b0;
            r_b_byp_data <= '0;
        end else if (w_re_b) begin
            r_b_byp      <= w_collide;
            r_b_byp_data <= a_din;
        end
    end

    assign b_dout = r_b_byp ? r_b_byp_data : w_q_b;
`else
    assign b_dout = w_q_b;
`endif

    assign busy        = r_busy;
    assign err         = r_err;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_ram_dp_ctl.sv
// Self-checking bench for ram_dp_ctl: clear timing, table vectors, random
// traffic against an array model, and reset/err corner sequences.
module tb_ram_dp_ctl;
    import ram_pkg::*;

`ifdef RAM_DP_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    localparam int DW    = 16;
    localparam int AW    = 8;
    localparam int DEPTH = 256;
    localparam logic [DW-1:0] CLR = 16'h0000;

    logic          clk;
    logic          reset_n;
    logic          a_en;
    logic          a_we;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_din;
    logic [DW-1:0] a_dout;
    logic          b_en;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_dout;
    logic          busy;
    logic          err;
    state_t        dbg_state;

    int checks;
    int failures;

    typedef struct {
        logic          a_en;
        logic          a_we;
        logic [AW-1:0] a_addr;
        logic [DW-1:0] a_din;
        logic          b_en;
        logic [AW-1:0] b_addr;
        logic [DW-1:0] exp_a;
        logic [DW-1:0] exp_b;
    } vec_t;

    vec_t          tbl[8];
    logic [DW-1:0] mem_m [DEPTH];
    logic [2*DW-1:0] exp_q[$];

    ram_dp_ctl #(
        .DATA_W  (DW),
        .ADDR_W  (AW),
        .CLR_VAL (CLR)
    ) dut (
        .clock       (clk),
        .reset_n     (reset_n),
        .a_en        (a_en),
        .a_we        (a_we),
        .a_addr      (a_addr),
        .a_din       (a_din),
        .a_dout      (a_dout),
        .b_en        (b_en),
        .b_addr      (b_addr),
        .b_dout      (b_dout),
        .busy        (busy),
        .err         (err),
        .o_dbg_state (dbg_state)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        a_en   = 1'b0;
        a_we   = 1'b0;
        b_en   = 1'b0;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic count_clear(input int start, output int n);
        n = start;
        while (busy && n < 1000) begin
            tick();
            n++;
        end
    endtask

    task automatic write_a(input logic [AW-1:0] addr, input logic [DW-1:0] d);
        a_en = 1'b1; a_we = 1'b1; a_addr = addr; a_din = d;
        tick();
        idle();
    endtask

    task automatic read_a(input logic [AW-1:0] addr);
        a_en = 1'b1; a_we = 1'b0; a_addr = addr;
        tick();
        idle();
    endtask

    task automatic read_b(input logic [AW-1:0] addr);
        b_en = 1'b1; b_addr = addr;
        tick();
        idle();
    endtask

    task automatic assert_reset_checks(input string tag);
        reset_n = 1'b0;
        #2;
        check({tag, "_busy"},  32'(busy), 32'd1);
        check({tag, "_err"},   32'(err), 32'd0);
        check({tag, "_adout"}, 32'(a_dout), 32'd0);
        check({tag, "_bdout"}, 32'(b_dout), 32'd0);
        check({tag, "_state"}, 32'(dbg_state), 32'(CLEAR));
    endtask

    initial begin
        int n;
        logic [AW-1:0] aa, ba;
        logic [DW-1:0] din, ea, eb;
        logic ae, we, be;
        logic [2*DW-1:0] e;

        checks = 0;
        failures = 0;
        reset_n = 1'b1;
        a_addr = '0;
        a_din = '0;
        b_addr = '0;
        idle();
        #3;

        // Reset state and first clear timing
        assert_reset_checks("rst0");
        tick();
        tick();
        reset_n = 1'b1;
        count_clear(0, n);
        check("clear_cycles", 32'(n), 32'd256);
        check("clear_err", 32'(err), 32'd0);
        check("ready_state", 32'(dbg_state), 32'(READY));

        for (int i = 0; i < DEPTH; i++) begin
            read_b(AW'(i));
            check("clear_word", 32'(b_dout), 32'(CLR));
        end

        // Table vectors: read-before-write, collision, hold
        tbl[0] = '{1'b1, 1'b1, 8'h10, 16'hA5A5, 1'b0, 8'h00, 16'h0000, 16'h0000};
        tbl[1] = '{1'b1, 1'b0, 8'h10, 16'h0000, 1'b0, 8'h00, 16'hA5A5, 16'h0000};
        tbl[2] = '{1'b1, 1'b1, 8'h10, 16'h1234, 1'b0, 8'h00, 16'hA5A5, 16'h0000};
        tbl[3] = '{1'b1, 1'b0, 8'h10, 16'h0000, 1'b0, 8'h00, 16'h1234, 16'h0000};
        tbl[4] = '{1'b1, 1'b1, 8'h20, 16'hBEEF, 1'b1, 8'h20, 16'h0000,
                   (BYP ? 16'hBEEF : 16'h0000)};
        tbl[5] = '{1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 8'h20, 16'h0000, 16'hBEEF};
        tbl[6] = '{1'b1, 1'b0, 8'h20, 16'h0000, 1'b1, 8'h10, 16'hBEEF, 16'h1234};
        tbl[7] = '{1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 16'hBEEF, 16'h1234};

        for (int i = 0; i < 8; i++) begin
            a_en = tbl[i].a_en; a_we = tbl[i].a_we; a_addr = tbl[i].a_addr;
            a_din = tbl[i].a_din; b_en = tbl[i].b_en; b_addr = tbl[i].b_addr;
            tick();
            check($sformatf("vec%0d_a", i), 32'(a_dout), 32'(tbl[i].exp_a));
            check($sformatf("vec%0d_b", i), 32'(b_dout), 32'(tbl[i].exp_b));
        end
        idle();
        for (int i = 0; i < 10; i++) begin
            a_addr = AW'($urandom_range(0, 255));
            b_addr = AW'($urandom_range(0, 255));
            tick();
            check("hold_a", 32'(a_dout), 32'h0000_BEEF);
            check("hold_b", 32'(b_dout), 32'h0000_1234);
        end

        // Random traffic against array model
        for (int i = 0; i < DEPTH; i++) mem_m[i] = CLR;
        mem_m[8'h10] = 16'h1234;
        mem_m[8'h20] = 16'hBEEF;
        ea = 16'hBEEF;
        eb = 16'h1234;
        for (int i = 0; i < 400; i++) begin
            ae  = 1'($urandom_range(0, 1));
            we  = 1'($urandom_range(0, 1));
            be  = 1'($urandom_range(0, 1));
            aa  = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 255)) : AW'($urandom_range(0, 7));
            ba  = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 255)) : AW'($urandom_range(0, 7));
            din = DW'($urandom);
            if (ae) ea = mem_m[aa];
            if (be) eb = (BYP && ae && we && aa == ba) ? din : mem_m[ba];
            if (ae && we) mem_m[aa] = din;
            exp_q.push_back({ea, eb});
            a_en = ae; a_we = we; a_addr = aa; a_din = din; b_en = be; b_addr = ba;
            tick();
            e = exp_q.pop_front();
            check("rand_a", 32'(a_dout), 32'(e[2*DW-1:DW]));
            check("rand_b", 32'(b_dout), 32'(e[DW-1:0]));
        end
        idle();

        // Access during clear: ignored, err sticky until reset
        write_a(8'h40, 16'h5A5A);
        assert_reset_checks("rst1");
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        a_en = 1'b1; a_we = 1'b1; a_addr = 8'h02; a_din = 16'hDEAD;
        b_en = 1'b1; b_addr = 8'h02;
        tick();
        idle();
        check("busy_err_set", 32'(err), 32'd1);
        check("busy_adout_hold", 32'(a_dout), 32'd0);
        check("busy_bdout_hold", 32'(b_dout), 32'd0);
        count_clear(5, n);
        check("clear_cycles_err", 32'(n), 32'd256);
        check("err_after_clear", 32'(err), 32'd1);
        read_a(8'h02);
        check("ignored_write", 32'(a_dout), 32'(CLR));
        read_b(8'h40);
        check("ready_reclear", 32'(b_dout), 32'(CLR));
        for (int i = 0; i < 5; i++) tick();
        check("err_sticky", 32'(err), 32'd1);

        // Reset mid-clear restarts from address 0
        write_a(8'h80, 16'h7777);
        read_a(8'h80);
        check("pre_a80", 32'(a_dout), 32'h0000_7777);
        read_b(8'h80);
        check("pre_b80", 32'(b_dout), 32'h0000_7777);
        assert_reset_checks("rst2");
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 100; i++) tick();
        check("mid_busy", 32'(busy), 32'd1);
        assert_reset_checks("rst3");
        tick();
        reset_n = 1'b1;
        count_clear(0, n);
        check("restart_cycles", 32'(n), 32'd256);
        read_b(8'h80);
        check("restart_b80", 32'(b_dout), 32'(CLR));
        read_a(8'h80);
        check("restart_a80", 32'(a_dout), 32'(CLR));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ram_dp_ctl.md
RAM_DP_CTL -- requirements
Module: ram_dp_ctl

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning word width in bits.
REQ-002 SHALL have parameter ADDR_W, default 8, meaning address width; depth is 2**ADDR_W words.
REQ-003 SHALL have parameter CLR_VAL, default 0, meaning the word written to every location by the power-up clear.
REQ-004 SHALL have port clock  input  1  sole clock, rising edge.
REQ-005 SHALL have port reset_n  input  1  asynchronous reset, active low.
REQ-006 SHALL have port a_en  input  1  port A (data) access request.
REQ-007 SHALL have port a_we  input  1  port A write enable, qualified by a_en.
REQ-008 SHALL have port a_addr  input  ADDR_W  port A address.
REQ-009 SHALL have port a_din  input  DATA_W  port A write data.
REQ-010 SHALL have port a_dout  output  DATA_W  port A registered read data.
REQ-011 SHALL have port b_en  input  1  port B (instruction fetch) read request.
REQ-012 SHALL have port b_addr  input  ADDR_W  port B address.
REQ-013 SHALL have port b_dout  output  DATA_W  port B registered read data.
REQ-014 SHALL have port busy  output  1  high while power-up clear runs.
REQ-015 SHALL have port err  output  1  sticky: access requested while busy.

Function
REQ-016 SHALL implement a two-state FSM: CLEAR (entered on reset) and READY.
REQ-017 In CLEAR, a clear counter SHALL write CLR_VAL to address cnt each cycle, cnt incrementing 0 to 2**ADDR_W-1.
REQ-018 The FSM SHALL move CLEAR->READY on the cycle the last address is written; busy falls in the same edge; no wrap of cnt beyond the last address.
REQ-019 In CLEAR, a_en and b_en SHALL be ignored: no array write, a_dout/b_dout hold value, err set to 1 if either is high.
REQ-020 In READY, a_en=1 SHALL load a_dout with mem[a_addr] one cycle later (latency 1).
REQ-021 In READY, a_en=1 with a_we=1 SHALL write a_din to mem[a_addr]; a_dout returns the old word (read-before-write).
REQ-022 In READY, b_en=1 SHALL load b_dout with mem[b_addr] one cycle later.
REQ-023 a_en=0 / b_en=0 SHALL hold the respective dout unchanged.
REQ-024 Port B same-address read while port A writes SHALL follow REQ-031/032.
REQ-025 err SHALL clear only on reset.

Reset
REQ-026 reset_n low SHALL asynchronously force: state=CLEAR, cnt=0, busy=1, err=0, a_dout=0, b_dout=0.
REQ-027 Reset asserted mid-clear SHALL restart the clear from address 0.
REQ-028 Reset asserted in READY SHALL re-run the full clear; array contents are not reset asynchronously.
REQ-029 Clear writes SHALL begin on the first rising clock edge after reset_n deasserts.

Configuration
REQ-030 Macro RAM_DP_BYPASS_EN SHALL select port-B collision behaviour.
REQ-031 With RAM_DP_BYPASS_EN defined: when a_en&a_we&b_en and a_addr==b_addr, b_dout SHALL receive a_din (write-through).
REQ-032 Without it: b_dout SHALL receive the old word at that address.

Structure
REQ-033 A shared package ram_pkg SHALL hold the FSM state typedef (CLEAR, READY) and default DATA_W/ADDR_W constants.
REQ-034 The storage array SHALL be a sub-module ram_dp_array (one write port, two synchronous read ports); ram_dp_ctl holds FSM, clear counter, muxing, bypass and err.

Verification
REQ-035 Release reset, ADDR_W=8 -> busy high exactly 256 cycles, then 0; read every address on port B -> all 0x0000.
REQ-036 READY: write 0xA5A5 to A addr 0x10, next cycle read A 0x10 -> a_dout=0xA5A5; write 0x1234 to 0x10 -> a_dout shows 0xA5A5 that cycle.
REQ-037 Same cycle A writes 0xBEEF to 0x20 (old 0x0000), B reads 0x20 -> b_dout=0xBEEF with RAM_DP_BYPASS_EN, 0x0000 without.
REQ-038 Pulse a_en during cycle 5 of CLEAR -> no write, err=1 and stays 1 after busy falls until reset.
REQ-039 Assert reset_n low at clear cycle 100, release -> busy high a further full 256 cycles; address 0x80 reads CLR_VAL.
REQ-040 a_en=b_en=0 for 10 cycles after reads -> a_dout/b_dout unchanged.
